// File: rtl/viterbi_frame_ctrl_pkg.sv
// Shared types and defaults for the Viterbi frame controller (package viterbi_pkg).
package viterbi_pkg;

  localparam int FRAME_LEN_DEF = 256;
  localparam int TAIL_LEN_DEF  = 8;
  localparam int DEC_LAT_DEF   = 16;

  typedef logic [1:0] sym_t;

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_TAIL, S_DRAIN, S_DONE} state_t;

  // Phase counter width: wide enough to count 0..len-1 for the longest phase.
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/viterbi_frame_ctrl_if.sv
// Source / encoder / decoder side signals of the frame controller.
interface viterbi_frame_ctrl_if;
  import viterbi_pkg::*;

  logic src_bit_i;
  logic src_rd_o;
  logic enc_en_o;
  logic enc_bit_o;
  logic enc_valid_i;
  sym_t enc_sym_i;
  logic dec_en_o;
  sym_t chan_sym_o;

  modport master (
    input  src_bit_i, enc_valid_i, enc_sym_i,
    output src_rd_o, enc_en_o, enc_bit_o, dec_en_o, chan_sym_o
  );

  modport slave (
    output src_bit_i, enc_valid_i, enc_sym_i,
    input  src_rd_o, enc_en_o, enc_bit_o, dec_en_o, chan_sym_o
  );
endinterface

// File: rtl/viterbi_frame_ctrl_err_inj.sv
// Channel error injector: periodic 2-symbol bursts with bit 0 inverted.
module viterbi_err_inj
  import viterbi_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        active_i,
  input  logic        valid_i,
  input  logic [7:0]  period_i,
  input  sym_t        sym_i,
  output sym_t        sym_o,
  output logic [15:0] inj_cnt_o
);

  logic [7:0]  r_period;
  logic [7:0]  r_scnt;
  logic        r_burst;
  logic [15:0] r_inj;
  logic        w_hit;
  logic        w_flip;

  assign w_hit     = (r_period != 8'd0) && (r_scnt == r_period - 8'd1);
  assign w_flip    = active_i && valid_i && (r_burst || w_hit);
  assign sym_o     = {sym_i[1], sym_i[0] ^ w_flip};
  assign inj_cnt_o = r_inj;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_period <= '0;
      r_scnt   <= '0;
      r_burst  <= 1'b0;
      r_inj    <= '0;
    end else if (clr_i) begin
      r_period <= period_i;
      r_scnt   <= '0;
      r_burst  <= 1'b0;
      r_inj    <= '0;
    end else if (!active_i) begin
      // A burst tail still pending when the frame ends is dropped.
      r_burst <= 1'b0;
    end else if (valid_i) begin
      if (r_burst) begin
        r_burst <= 1'b0;
      end else if (w_hit) begin
        r_scnt  <= '0;
        r_burst <= 1'b1;
      end else if (r_period != 8'd0) begin
        r_scnt <= r_scnt + 8'd1;
      end
      if (w_flip && (r_inj != 16'hFFFF)) r_inj <= r_inj + 16'd1;
    end
  end

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for encoder -> channel -> decoder: DATA, TAIL flush, decoder drain.
// Optional error injection is built in when VITERBI_ERR_INJECT_EN is defined.
module viterbi_frame_ctrl
  import viterbi_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int TAIL_LEN  = TAIL_LEN_DEF,
  parameter int DEC_LAT   = DEC_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [7:0]           err_period_i,
  viterbi_frame_ctrl_if.master bus,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [15:0]          inj_cnt_o
);

  localparam int CW = cnt_w(FRAME_LEN, TAIL_LEN, DEC_LAT);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_enc_en;
  logic          r_src_rd;
  logic          r_busy;
  logic          r_done;
  logic          r_dec_en;
  sym_t          r_chan_sym;
  sym_t          w_sym;
  logic          w_start;

  assign w_start = (r_state == S_IDLE) && start_i;

  assign bus.src_rd_o   = r_src_rd;
  assign bus.enc_en_o   = r_enc_en;
  assign bus.enc_bit_o  = r_src_rd & bus.src_bit_i;
  assign bus.dec_en_o   = r_dec_en;
  assign bus.chan_sym_o = r_chan_sym;
  assign busy_o         = r_busy;
  assign done_o         = r_done;

`ifdef VITERBI_ERR_INJECT_EN
  viterbi_err_inj u_inj (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (w_start),
    .active_i  (r_busy),
    .valid_i   (bus.enc_valid_i),
    .period_i  (err_period_i),
    .sym_i     (bus.enc_sym_i),
    .sym_o     (w_sym),
    .inj_cnt_o (inj_cnt_o)
  );
`else
  logic w_unused_period;
  assign w_unused_period = ^err_period_i;
  assign w_sym           = bus.enc_sym_i;
  assign inj_cnt_o       = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_enc_en   <= 1'b0;
      r_src_rd   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dec_en   <= 1'b0;
      r_chan_sym <= '0;
    end else begin
      // Channel path runs in every state, independent of the sequencer.
      r_dec_en   <= bus.enc_valid_i;
      r_chan_sym <= w_sym;
      case (r_state)
        S_IDLE: if (w_start) begin
          r_state  <= S_DATA;
          r_cnt    <= '0;
          r_enc_en <= 1'b1;
          r_src_rd <= 1'b1;
          r_busy   <= 1'b1;
        end
        S_DATA: if (r_cnt == CW'(FRAME_LEN - 1)) begin
          r_state  <= S_TAIL;
          r_cnt    <= '0;
          r_src_rd <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        S_TAIL: if (r_cnt == CW'(TAIL_LEN - 1)) begin
          r_state  <= S_DRAIN;
          r_cnt    <= '0;
          r_enc_en <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        S_DRAIN: if (r_cnt == CW'(DEC_LAT - 1)) begin
          r_state <= S_DONE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
